// File: rtl/panel_input_conditioner.sv
// Front-panel input conditioner: two-flop synchronisers, tick-based debounce for
// 16 data switches, the manual clock button and the mode switch, plus press/auto-repeat strobes.
module panel_input_conditioner #(
  parameter int TICK_CYCLES  = 1000,
  parameter int STABLE_TICKS = 8,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int CNT_W        = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] sw_raw,
  input  logic        mclk_raw,
  input  logic        switch_raw,
  input  logic        repeat_en,
  output logic [15:0] sw_clean,
  output logic        mclk_clean,
  output logic        switch_clean,
  output logic        mclk_pulse,
  output logic        sw_change,
  output logic        tick
);

  localparam int NCH    = 18;
  localparam int STAB_W = 4;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_CYCLES - 1);
  // Clamp to at least one tick so two strobes can never land on adjacent cycles.
  localparam logic [CNT_W-1:0]  DELAY_TICKS = CNT_W'((REPEAT_DELAY < 1) ? 1 : REPEAT_DELAY);
  localparam logic [CNT_W-1:0]  RATE_TICKS  = CNT_W'((REPEAT_RATE < 1) ? 1 : REPEAT_RATE);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

  logic [NCH-1:0]    sync_p0, sync_p1, clean_p2;
  logic [STAB_W-1:0] stab_cnt [NCH];
  logic [CNT_W-1:0]  pre_cnt;
  logic [15:0]       sw_prev;
  logic              mclk_prev, mclk_rise;
  rpt_state_t        state, state_nxt;
  logic [CNT_W-1:0]  rpt_cnt, rpt_cnt_nxt;
  logic              pulse_nxt;

  assign tick         = (pre_cnt == TICK_LAST);
  assign sw_clean     = clean_p2[15:0];
  assign mclk_clean   = clean_p2[16];
  assign switch_clean = clean_p2[17];
  assign mclk_rise    = mclk_clean & ~mclk_prev;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Stage p0/p1: metastability chain for all 18 channels
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {switch_raw, mclk_raw, sw_raw};
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: clean level follows sync only after STABLE_TICKS differing ticks
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clean_p2 <= '0;
      for (int i = 0; i < NCH; i++) stab_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < NCH; i++) begin
        if (sync_p1[i] == clean_p2[i]) begin
          stab_cnt[i] <= '0;
        end else if (stab_cnt[i] >= STAB_LAST) begin
          clean_p2[i] <= sync_p1[i];
          stab_cnt[i] <= '0;
        end else begin
          stab_cnt[i] <= stab_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sw_prev    <= '0;
      sw_change  <= 1'b0;
      mclk_prev  <= 1'b0;
      mclk_pulse <= 1'b0;
      state      <= IDLE;
      rpt_cnt    <= '0;
    end else begin
      sw_prev    <= sw_clean;
      sw_change  <= |(sw_clean ^ sw_prev);
      mclk_prev  <= mclk_clean;
      mclk_pulse <= pulse_nxt;
      state      <= state_nxt;
      rpt_cnt    <= rpt_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    pulse_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (mclk_rise) begin
          pulse_nxt   = 1'b1;
          rpt_cnt_nxt = '0;
          state_nxt   = DELAY;
        end
      end
      DELAY: begin
        // With repeat disabled the counter freezes and the press stays single-shot.
        if (!mclk_clean) begin
          state_nxt = IDLE;
        end else if (repeat_en) begin
          if (rpt_cnt >= DELAY_TICKS) begin
            pulse_nxt   = 1'b1;
            rpt_cnt_nxt = '0;
            state_nxt   = REPEAT;
          end else if (tick) begin
            rpt_cnt_nxt = rpt_cnt + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!mclk_clean || !repeat_en) begin
          state_nxt = IDLE;
        end else if (rpt_cnt >= RATE_TICKS) begin
          pulse_nxt   = 1'b1;
          rpt_cnt_nxt = '0;
        end else if (tick) begin
          rpt_cnt_nxt = rpt_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
